apb_master_module: RTL and testbench

- APB initiator that drives the matmul accelerator's APB slave port from a simple command interface, for a host or sequencer.
- Commands (read/write, address, data, strobe) are queued in a small FIFO, then issued as APB SETUP/ACCESS transfers.
- Each transfer waits for pready, or a timeout, and returns a one-cycle response carrying read data and error status.

---
 rtl/apb_master_pkg.sv | 27 ++
 rtl/apb_cmd_fifo_module.sv | 53 +++++
 rtl/apb_master_module.sv | 140 ++++++++++++++
 tb/tb_apb_master_module.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_master_pkg.sv
// Shared definitions for the APB command master: FSM encoding, default widths
// and the matmul accelerator register map used by sequencers and benches.
package apb_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_BUS_WIDTH  = 16;

  // One strobe bit per element lane on the bus.
  function automatic int strb_width(input int bus_width, input int data_width);
    return bus_width / data_width;
  endfunction

  localparam int MAX_DIM = strb_width(DEF_BUS_WIDTH, DEF_DATA_WIDTH);

  localparam logic [31:0] MATMUL_CTRL_OFFSET    = 32'h0000_0000;
  localparam logic [31:0] MATMUL_OP_A_OFFSET    = 32'h0000_0004;
  localparam logic [31:0] MATMUL_OP_B_OFFSET    = 32'h0000_0008;
  localparam logic [31:0] MATMUL_FLAGS_OFFSET   = 32'h0000_000C;
  localparam logic [31:0] MATMUL_SCRATCH_OFFSET = 32'h0000_0010;

endpackage

// File: rtl/apb_cmd_fifo_module.sv
// Synchronous show-ahead FIFO holding queued APB commands; no same-cycle bypass.
module apb_cmd_fifo_module #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count == CNT_W'(DEPTH));
  assign empty_o = (count == '0);
  assign count_o = count;
  assign rdata_o = mem[rd_ptr];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // NOTE: storage is not reset; an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata_i;
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/apb_master_module.sv
// APB initiator: queues host commands and issues them as SETUP/ACCESS transfers
// with a per-transfer pready timeout and a one-cycle response pulse.
module apb_master_module
  import apb_master_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BUS_WIDTH  = 16,
  parameter int ADDR_WIDTH = 32,
  parameter int CMD_DEPTH  = 4,
  parameter int TIMEOUT    = 16,
  localparam int STRB_W    = strb_width(BUS_WIDTH, DATA_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [BUS_WIDTH-1:0]  cmd_wdata_i,
  input  logic [STRB_W-1:0]     cmd_strb_i,
  output logic                  rsp_valid_o,
  output logic [BUS_WIDTH-1:0]  rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  rsp_timeout_o,
  output logic                  busy_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [BUS_WIDTH-1:0]  pwdata_o,
  output logic [STRB_W-1:0]     pstrb_o,
  input  logic                  pready_i,
  input  logic                  pslverr_i,
  input  logic [BUS_WIDTH-1:0]  prdata_i
);

  localparam int CMD_W = ADDR_WIDTH + BUS_WIDTH + STRB_W + 1;
  localparam int CNT_W = $clog2(CMD_DEPTH) + 1;
  localparam int TMO_W = $clog2(TIMEOUT);

  apb_state_e state, state_n;

  logic [CMD_W-1:0]      fifo_rdata;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_pop;
  logic                  xfer_done;
  logic                  xfer_abort;
  logic [TMO_W-1:0]      tmo_cnt;

  logic                  x_write;
  logic [ADDR_WIDTH-1:0] x_addr;
  logic [BUS_WIDTH-1:0]  x_wdata;
  logic [STRB_W-1:0]     x_strb;

  apb_cmd_fifo_module #(
    .WIDTH (CMD_W),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (cmd_valid_i && cmd_ready_o),
    .wdata_i ({cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign cmd_ready_o = !fifo_full;
  assign busy_o      = (fifo_count != '0) || (state != ST_IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_n;
  end

  // NOTE: every output of this block gets a default first, so no latch can form.
  always_comb begin
    state_n    = state;
    fifo_pop   = 1'b0;
    xfer_done  = 1'b0;
    xfer_abort = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_n  = ST_SETUP;
        end
      end
      ST_SETUP: state_n = ST_ACCESS;
      ST_ACCESS: begin
        // pready in the last allowed cycle still wins over the abort.
        if (pready_i)                             xfer_done  = 1'b1;
        else if (tmo_cnt == TMO_W'(TIMEOUT - 1))  xfer_abort = 1'b1;
        if (xfer_done || xfer_abort) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_n  = ST_SETUP;
          end else begin
            state_n  = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      x_write       <= 1'b0;
      x_addr        <= '0;
      x_wdata       <= '0;
      x_strb        <= '0;
      tmo_cnt       <= '0;
      rsp_valid_o   <= 1'b0;
      rsp_rdata_o   <= '0;
      rsp_err_o     <= 1'b0;
      rsp_timeout_o <= 1'b0;
    end else begin
      if (fifo_pop) {x_write, x_addr, x_wdata, x_strb} <= fifo_rdata;
      tmo_cnt       <= (state == ST_ACCESS && !pready_i && !xfer_abort) ?
                       tmo_cnt + TMO_W'(1) : '0;
      rsp_valid_o   <= xfer_done || xfer_abort;
      rsp_rdata_o   <= (xfer_done && !x_write) ? prdata_i : '0;
      rsp_err_o     <= xfer_abort || (xfer_done && pslverr_i);
      rsp_timeout_o <= xfer_abort;
    end
  end

  assign psel_o    = (state == ST_SETUP) || (state == ST_ACCESS);
  assign penable_o = (state == ST_ACCESS);
  assign pwrite_o  = x_write;
  assign paddr_o   = x_addr;
  assign pwdata_o  = x_wdata;
  assign pstrb_o   = x_write ? x_strb : '0;

endmodule

// File: tb/tb_apb_master_module.sv
// Scoreboard bench for apb_master_module: a scripted APB slave with per-command
// wait states, queued expected responses, and directed timing/reset scenarios.
module tb_apb_master_module;
  import apb_master_pkg::*;

  localparam int NEVER = 1000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_write_i;
  logic [31:0] cmd_addr_i;
  logic [15:0] cmd_wdata_i;
  logic [1:0]  cmd_strb_i;
  logic        rsp_valid_o;
  logic [15:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        rsp_timeout_o;
  logic        busy_o;
  logic        psel_o;
  logic        penable_o;
  logic        pwrite_o;
  logic [31:0] paddr_o;
  logic [15:0] pwdata_o;
  logic [1:0]  pstrb_o;
  logic        pready_i;
  logic        pslverr_i;
  logic [15:0] prdata_i;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [15:0] wdata;
    logic [1:0]  strb;
    int          waits;
    logic        slverr;
    logic [15:0] rdata;
  } cmd_t;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    logic        tmo;
    int          len;
  } rsp_t;

  cmd_t apb_q[$];
  rsp_t rsp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  apb_master_module #(
    .DATA_WIDTH (8),
    .BUS_WIDTH  (16),
    .ADDR_WIDTH (32),
    .CMD_DEPTH  (4),
    .TIMEOUT    (16)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .cmd_valid_i   (cmd_valid_i),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_write_i   (cmd_write_i),
    .cmd_addr_i    (cmd_addr_i),
    .cmd_wdata_i   (cmd_wdata_i),
    .cmd_strb_i    (cmd_strb_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_rdata_o   (rsp_rdata_o),
    .rsp_err_o     (rsp_err_o),
    .rsp_timeout_o (rsp_timeout_o),
    .busy_o        (busy_o),
    .psel_o        (psel_o),
    .penable_o     (penable_o),
    .pwrite_o      (pwrite_o),
    .paddr_o       (paddr_o),
    .pwdata_o      (pwdata_o),
    .pstrb_o       (pstrb_o),
    .pready_i      (pready_i),
    .pslverr_i     (pslverr_i),
    .prdata_i      (prdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scripted slave and response monitor; everything is sampled/driven on negedge.
  cmd_t cur;
  bit   in_xfer = 0;
  int   acc_cnt = 0;

  always @(negedge clk_i) begin
    if (rst_i) begin
      in_xfer   = 0;
      pready_i  = 1'b0;
      pslverr_i = 1'b0;
      prdata_i  = '0;
    end else begin
      if (rsp_valid_o) begin
        if (rsp_q.size() == 0) begin
          check("rsp_unexpected", 1, 0);
        end else begin
          rsp_t e;
          e = rsp_q.pop_front();
          check("rsp_rdata", rsp_rdata_o, e.rdata);
          check("rsp_err", rsp_err_o, e.err);
          check("rsp_timeout", rsp_timeout_o, e.tmo);
          check("access_len", acc_cnt, e.len);
        end
      end
      pready_i  = 1'b0;
      pslverr_i = 1'b0;
      prdata_i  = 16'h5A5A;
      if (psel_o && !penable_o) begin
        if (apb_q.size() == 0) begin
          check("setup_unexpected", 1, 0);
        end else begin
          cur     = apb_q.pop_front();
          in_xfer = 1;
          acc_cnt = 0;
          check("setup_paddr", paddr_o, cur.addr);
          check("setup_pwrite", pwrite_o, cur.write);
          check("setup_pstrb", pstrb_o, cur.write ? cur.strb : 2'b00);
          if (cur.write) check("setup_pwdata", pwdata_o, cur.wdata);
        end
      end else if (psel_o && penable_o && in_xfer) begin
        check("access_paddr", paddr_o, cur.addr);
        check("access_ctrl", {pwrite_o, pstrb_o}, {cur.write, cur.write ? cur.strb : 2'b00});
        if (acc_cnt == cur.waits) begin
          pready_i  = 1'b1;
          pslverr_i = cur.slverr;
          prdata_i  = cur.rdata;
        end else begin
          prdata_i  = 16'($urandom);
        end
        acc_cnt++;
      end
    end
  end

  // Offer one command; on acceptance push the expected APB transfer and response.
  task automatic send_cmd(input logic write, input logic [31:0] addr, input logic [15:0] wdata,
                          input logic [1:0] strb, input int waits, input logic slverr,
                          input logic [15:0] rdata);
    cmd_t c;
    rsp_t r;
    bit   accepted = 0;
    c = '{write, addr, wdata, strb, waits, slverr, rdata};
    if (waits > 15) r = '{16'h0, 1'b1, 1'b1, 16};
    else            r = '{write ? 16'h0 : rdata, slverr, 1'b0, waits + 1};
    cmd_valid_i = 1'b1;
    cmd_write_i = write;
    cmd_addr_i  = addr;
    cmd_wdata_i = wdata;
    cmd_strb_i  = strb;
    for (int n = 0; n < 200 && !accepted; n++) begin
      accepted = cmd_ready_o;
      if (accepted) begin
        apb_q.push_back(c);
        rsp_q.push_back(r);
      end
      @(negedge clk_i);
    end
    cmd_valid_i = 1'b0;
    if (!accepted) check("accept_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int n = 0; n < 300 && !done; n++) begin
      done = (rsp_q.size() == 0) && !busy_o;
      if (!done) @(negedge clk_i);
    end
    if (!done) check("idle_timeout", 0, 1);
  endtask

  initial begin
    rst_i       = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_write_i = 1'b0;
    cmd_addr_i  = '0;
    cmd_wdata_i = '0;
    cmd_strb_i  = '0;
    repeat (2) @(negedge clk_i);
    check("rst_cmd_ready", cmd_ready_o, 1);
    check("rst_psel_penable", {psel_o, penable_o}, 2'b00);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_paddr", paddr_o, 0);
    check("rst_pstrb_pwrite", {pstrb_o, pwrite_o}, 3'b000);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Single zero-wait write: exact cycle positions of SETUP, ACCESS, response.
    send_cmd(1'b1, MATMUL_SCRATCH_OFFSET, 16'h1234, 2'b11, 0, 1'b0, 16'hCAFE);
    check("t1_psel", psel_o, 0);
    @(negedge clk_i);
    check("t2_setup", {psel_o, penable_o}, 2'b10);
    check("t2_paddr", paddr_o, 32'h10);
    check("t2_pstrb", pstrb_o, 2'b11);
    @(negedge clk_i);
    check("t3_access", {psel_o, penable_o}, 2'b11);
    @(negedge clk_i);
    check("t4_rsp_valid", rsp_valid_o, 1);
    wait_idle();

    // Read with 3 wait states.
    send_cmd(1'b0, MATMUL_OP_A_OFFSET, 16'h0000, 2'b11, 3, 1'b0, 16'hBEEF);
    wait_idle();

    // Fill the FIFO behind a slow transfer, then watch the back-to-back train.
    send_cmd(1'b1, MATMUL_CTRL_OFFSET, 16'h0001, 2'b01, 8, 1'b0, 16'h1111);
    send_cmd(1'b1, MATMUL_OP_B_OFFSET, 16'hA5A5, 2'b10, 0, 1'b0, 16'h2222);
    send_cmd(1'b0, MATMUL_FLAGS_OFFSET, 16'h0000, 2'b11, 0, 1'b0, 16'h3333);
    send_cmd(1'b1, 32'h0000_0014, 16'h5678, 2'b11, 0, 1'b0, 16'h4444);
    send_cmd(1'b0, 32'h0000_0018, 16'h0000, 2'b01, 0, 1'b0, 16'h5555);
    check("full_ready", cmd_ready_o, 0);
    check("full_busy", busy_o, 1);
    fork
      send_cmd(1'b1, 32'h0000_001C, 16'h9ABC, 2'b11, 0, 1'b0, 16'h6666);
      begin
        for (int n = 0; n < 60 && !rsp_valid_o; n++) @(negedge clk_i);
        check("b2b_first_rsp", rsp_valid_o, 1);
        for (int i = 0; i < 8; i++) begin
          check("b2b_psel", psel_o, 1);
          check("b2b_penable", penable_o, i % 2);
          @(negedge clk_i);
        end
      end
    join
    wait_idle();

    // Timeout abort, boundary completion in the last allowed cycle, then a normal read.
    send_cmd(1'b1, MATMUL_CTRL_OFFSET, 16'h00FF, 2'b11, NEVER, 1'b0, 16'h7777);
    send_cmd(1'b0, MATMUL_OP_A_OFFSET, 16'h0000, 2'b11, 15, 1'b0, 16'h8888);
    send_cmd(1'b0, MATMUL_OP_B_OFFSET, 16'h0000, 2'b10, 1, 1'b0, 16'h9999);
    wait_idle();

    // Slave errors: write with pslverr, clean read (pstrb forced 0), read with pslverr.
    send_cmd(1'b1, MATMUL_FLAGS_OFFSET, 16'hDEAD, 2'b10, 0, 1'b1, 16'hAAAA);
    send_cmd(1'b0, MATMUL_FLAGS_OFFSET, 16'h0000, 2'b11, 2, 1'b0, 16'hBBBB);
    send_cmd(1'b0, MATMUL_SCRATCH_OFFSET, 16'h0000, 2'b01, 1, 1'b1, 16'hCCCC);
    wait_idle();

    // Asynchronous reset in ACCESS with two commands still queued.
    send_cmd(1'b1, MATMUL_CTRL_OFFSET, 16'h0F0F, 2'b11, NEVER, 1'b0, 16'h0);
    send_cmd(1'b1, MATMUL_OP_A_OFFSET, 16'h1F1F, 2'b11, 0, 1'b0, 16'h0);
    send_cmd(1'b1, MATMUL_OP_B_OFFSET, 16'h2F2F, 2'b11, 0, 1'b0, 16'h0);
    for (int n = 0; n < 20 && !(psel_o && penable_o); n++) @(negedge clk_i);
    check("pre_rst_access", {psel_o, penable_o}, 2'b11);
    #2 rst_i = 1'b1;
    #1;
    check("async_rst_psel_penable", {psel_o, penable_o}, 2'b00);
    check("async_rst_busy", busy_o, 0);
    check("async_rst_ready", cmd_ready_o, 1);
    check("async_rst_rsp_valid", rsp_valid_o, 0);
    apb_q.delete();
    rsp_q.delete();
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk_i);
      check("post_rst_quiet", {psel_o, rsp_valid_o, busy_o}, 3'b000);
    end

    send_cmd(1'b0, MATMUL_OP_A_OFFSET, 16'h0000, 2'b11, 0, 1'b0, 16'h4242);
    wait_idle();
    check("final_queue_empty", rsp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
